// File: rtl/combat_pkg.sv
// Shared encodings for the combat round engine: FSM states and winner codes.
package combat_pkg;

  typedef enum logic [1:0] {
    FIGHT      = 2'd0,
    ROUND_END  = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DRAW = 2'd3
  } winner_t;

endpackage

// File: rtl/combat_hit_check.sv
// Combinational hit geometry for one attacker/defender pair: overlap, level, facing.
module combat_hit_check #(
  parameter int POS_W = 10,
  parameter int HIT_W = 80
) (
  input  logic [POS_W-1:0] atk_x,
  input  logic [POS_W-1:0] atk_y,
  input  logic             atk_facing_left,
  input  logic [POS_W-1:0] def_x,
  input  logic [POS_W-1:0] def_y,
  output logic             hit_ok
);

  localparam logic [POS_W:0] HW = (POS_W+1)'(HIT_W);

  // One extra bit so x+HIT_W near the screen edge cannot wrap.
  logic [POS_W:0] ax, dx;
  logic           overlap, facing;

  always_comb begin
    ax      = {1'b0, atk_x};
    dx      = {1'b0, def_x};
    overlap = (ax < dx + HW) && (ax + HW > dx);
    facing  = atk_facing_left ? (ax > dx) : (ax < dx);
    hit_ok  = overlap && (atk_y == def_y) && facing;
  end

endmodule

// File: rtl/combat_round_engine.sv
// Two-player hit resolution, invulnerability, round timer and best-of-N match FSM.
// Hits land one cycle after the attack edge is sampled; round end is decided on the same edge as the hit.
module combat_round_engine
  import combat_pkg::*;
#(
  parameter int POS_W         = 10,
  parameter int HIT_W         = 80,
  parameter int HEALTH_W      = 4,
  parameter int HEALTH_MAX    = 15,
  parameter int DAMAGE        = 1,
  parameter int CHIP_DAMAGE   = 0,
  parameter int INVULN_CYCLES = 25_000_000,
  parameter int ROUND_TICKS   = 99,
  parameter int PAUSE_TICKS   = 3,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [POS_W-1:0]    p1_x,
  input  logic [POS_W-1:0]    p1_y,
  input  logic [POS_W-1:0]    p2_x,
  input  logic [POS_W-1:0]    p2_y,
  input  logic                p1_attack,
  input  logic                p2_attack,
  input  logic                p1_shield,
  input  logic                p2_shield,
  input  logic                p1_facing_left,
  input  logic                p2_facing_left,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic                p1_hit,
  output logic                p2_hit,
  output logic [1:0]          p1_rounds,
  output logic [1:0]          p2_rounds,
  output logic [6:0]          round_timer,
  output logic [1:0]          state,
  output logic [1:0]          round_winner,
  output logic [1:0]          match_winner,
  output logic                freeze
);

  localparam int INV_W = $clog2(INVULN_CYCLES + 2);
  localparam logic [INV_W-1:0]    INV_LOAD = INV_W'(INVULN_CYCLES);
  localparam logic [HEALTH_W-1:0] HMAX     = HEALTH_W'(HEALTH_MAX);
  localparam logic [HEALTH_W-1:0] DMG      = HEALTH_W'(DAMAGE);
  localparam logic [HEALTH_W-1:0] CHIP     = HEALTH_W'(CHIP_DAMAGE);
  localparam logic [6:0]          RT       = 7'(ROUND_TICKS);
  localparam logic [6:0]          PT       = 7'(PAUSE_TICKS);
  localparam logic [1:0]          RTW      = 2'(ROUNDS_TO_WIN);

  state_t              st, st_nxt;
  logic [INV_W-1:0]    inv1, inv2, inv1_nxt, inv2_nxt;
  logic [6:0]          pause, pause_nxt, timer_nxt;
  logic [HEALTH_W-1:0] h1_nxt, h2_nxt, dmg1, dmg2;
  logic [1:0]          r1_nxt, r2_nxt, rw_nxt, mw_nxt;
  logic                hit1_nxt, hit2_nxt;
  logic                prev1, prev2, rise1, rise2;
  logic                ok12, ok21, hit_on1, hit_on2, round_over;
  winner_t             w;

  combat_hit_check #(.POS_W(POS_W), .HIT_W(HIT_W)) u_hit_p1 (
    .atk_x(p1_x), .atk_y(p1_y), .atk_facing_left(p1_facing_left),
    .def_x(p2_x), .def_y(p2_y), .hit_ok(ok12)
  );

  combat_hit_check #(.POS_W(POS_W), .HIT_W(HIT_W)) u_hit_p2 (
    .atk_x(p2_x), .atk_y(p2_y), .atk_facing_left(p2_facing_left),
    .def_x(p1_x), .def_y(p1_y), .hit_ok(ok21)
  );

  assign hit_on2 = (st == FIGHT) && rise1 && ok12 && (inv2 == '0);
  assign hit_on1 = (st == FIGHT) && rise2 && ok21 && (inv1 == '0);
  assign dmg2    = p2_shield ? CHIP : DMG;
  assign dmg1    = p1_shield ? CHIP : DMG;
  assign state   = st;

  always_comb begin
    st_nxt     = st;
    h1_nxt     = p1_health;
    h2_nxt     = p2_health;
    hit1_nxt   = 1'b0;
    hit2_nxt   = 1'b0;
    inv1_nxt   = (inv1 != '0) ? inv1 - INV_W'(1) : '0;
    inv2_nxt   = (inv2 != '0) ? inv2 - INV_W'(1) : '0;
    r1_nxt     = p1_rounds;
    r2_nxt     = p2_rounds;
    timer_nxt  = round_timer;
    pause_nxt  = pause;
    rw_nxt     = round_winner;
    mw_nxt     = match_winner;
    w          = NONE;
    round_over = 1'b0;

    case (st)
      FIGHT: begin
        if (hit_on2 && dmg2 != '0) begin
          h2_nxt   = (p2_health > dmg2) ? p2_health - dmg2 : '0;
          hit2_nxt = 1'b1;
          inv2_nxt = INV_LOAD;
        end
        if (hit_on1 && dmg1 != '0) begin
          h1_nxt   = (p1_health > dmg1) ? p1_health - dmg1 : '0;
          hit1_nxt = 1'b1;
          inv1_nxt = INV_LOAD;
        end
        if (sec_tick && round_timer != '0)
          timer_nxt = round_timer - 7'd1;

        // A knockout on the same edge as the final tick wins over the timer verdict.
        if (h1_nxt == '0 || h2_nxt == '0) begin
          round_over = 1'b1;
          if (h1_nxt == '0 && h2_nxt == '0) w = DRAW;
          else if (h1_nxt == '0)            w = P2;
          else                              w = P1;
        end else if (sec_tick && timer_nxt == '0) begin
          round_over = 1'b1;
          if (h1_nxt > h2_nxt)      w = P1;
          else if (h2_nxt > h1_nxt) w = P2;
          else                      w = DRAW;
        end

        if (round_over) begin
          st_nxt    = ROUND_END;
          pause_nxt = PT;
          rw_nxt    = w;
          if (w == P1) r1_nxt = p1_rounds + 2'd1;
          if (w == P2) r2_nxt = p2_rounds + 2'd1;
        end
      end

      ROUND_END: begin
        if (sec_tick) begin
          pause_nxt = (pause != '0) ? pause - 7'd1 : '0;
          if (pause_nxt == '0) begin
            if (p1_rounds == RTW) begin
              st_nxt = MATCH_OVER;
              mw_nxt = P1;
            end else if (p2_rounds == RTW) begin
              st_nxt = MATCH_OVER;
              mw_nxt = P2;
            end else begin
              st_nxt    = FIGHT;
              h1_nxt    = HMAX;
              h2_nxt    = HMAX;
              timer_nxt = RT;
              inv1_nxt  = '0;
              inv2_nxt  = '0;
              rw_nxt    = NONE;
            end
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= FIGHT;
      p1_health    <= HMAX;
      p2_health    <= HMAX;
      p1_hit       <= 1'b0;
      p2_hit       <= 1'b0;
      inv1         <= '0;
      inv2         <= '0;
      p1_rounds    <= '0;
      p2_rounds    <= '0;
      round_timer  <= RT;
      pause        <= '0;
      round_winner <= NONE;
      match_winner <= NONE;
      freeze       <= 1'b0;
      prev1        <= 1'b0;
      prev2        <= 1'b0;
      rise1        <= 1'b0;
      rise2        <= 1'b0;
    end else begin
      st           <= st_nxt;
      p1_health    <= h1_nxt;
      p2_health    <= h2_nxt;
      p1_hit       <= hit1_nxt;
      p2_hit       <= hit2_nxt;
      inv1         <= inv1_nxt;
      inv2         <= inv2_nxt;
      p1_rounds    <= r1_nxt;
      p2_rounds    <= r2_nxt;
      round_timer  <= timer_nxt;
      pause        <= pause_nxt;
      round_winner <= rw_nxt;
      match_winner <= mw_nxt;
      freeze       <= (st_nxt != FIGHT);
      // Edge history runs in every state so a held button never strikes at round start.
      prev1        <= p1_attack;
      prev2        <= p2_attack;
      rise1        <= p1_attack & ~prev1;
      rise2        <= p2_attack & ~prev2;
    end
  end

endmodule

// File: tb/tb_combat_round_engine.sv
// Directed bench: full-block engine plus a chip-damage engine sharing the same stimulus.
module tb_combat_round_engine;

  logic       clk = 1'b0;
  logic       reset, sec_tick;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic       p1_attack, p2_attack, p1_shield, p2_shield, p1_facing_left, p2_facing_left;

  logic [3:0] p1_health, p2_health, c_p1_health, c_p2_health;
  logic       p1_hit, p2_hit, c_p1_hit, c_p2_hit;
  logic [1:0] p1_rounds, p2_rounds, c_p1_rounds, c_p2_rounds;
  logic [6:0] round_timer, c_round_timer;
  logic [1:0] state, round_winner, match_winner, c_state, c_round_winner, c_match_winner;
  logic       freeze, c_freeze;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  combat_round_engine #(.CHIP_DAMAGE(0), .INVULN_CYCLES(10), .ROUND_TICKS(3)) u_dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_attack(p1_attack), .p2_attack(p2_attack),
    .p1_shield(p1_shield), .p2_shield(p2_shield),
    .p1_facing_left(p1_facing_left), .p2_facing_left(p2_facing_left),
    .p1_health(p1_health), .p2_health(p2_health), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .round_timer(round_timer),
    .state(state), .round_winner(round_winner), .match_winner(match_winner), .freeze(freeze)
  );

  combat_round_engine #(.CHIP_DAMAGE(1), .INVULN_CYCLES(10), .ROUND_TICKS(3)) u_dut_chip (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_attack(p1_attack), .p2_attack(p2_attack),
    .p1_shield(p1_shield), .p2_shield(p2_shield),
    .p1_facing_left(p1_facing_left), .p2_facing_left(p2_facing_left),
    .p1_health(c_p1_health), .p2_health(c_p2_health), .p1_hit(c_p1_hit), .p2_hit(c_p2_hit),
    .p1_rounds(c_p1_rounds), .p2_rounds(c_p2_rounds), .round_timer(c_round_timer),
    .state(c_state), .round_winner(c_round_winner), .match_winner(c_match_winner),
    .freeze(c_freeze)
  );

  task automatic set_pos(input int x1, input int y1, input int x2, input int y2,
                         input logic f1, input logic f2);
    p1_x = 10'(x1); p1_y = 10'(y1); p2_x = 10'(x2); p2_y = 10'(y2);
    p1_facing_left = f1; p2_facing_left = f2;
  endtask

  task automatic do_reset();
    p1_attack = 1'b0; p2_attack = 1'b0; sec_tick = 1'b0;
    p1_shield = 1'b0; p2_shield = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise attacks; returns at the negedge just after the resolving edge.
  task automatic attack(input logic a1, input logic a2);
    p1_attack = a1; p2_attack = a2;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_wait(input int n);
    p1_attack = 1'b0; p2_attack = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      sec_tick = 1'b1;
      @(negedge clk);
      sec_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++; if (p1_health !== 4'd15) begin fails++; $display("FAIL reset_p1_health got %0d want 15", p1_health); end
    tests++; if (p2_health !== 4'd15) begin fails++; $display("FAIL reset_p2_health got %0d want 15", p2_health); end
    tests++; if (round_timer !== 7'd3) begin fails++; $display("FAIL reset_timer got %0d want 3", round_timer); end
    tests++; if ({p1_rounds, p2_rounds} !== 4'b0000) begin fails++; $display("FAIL reset_rounds got %0d/%0d want 0/0", p1_rounds, p2_rounds); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if ({round_winner, match_winner} !== 4'b0000) begin fails++; $display("FAIL reset_winners got %0d/%0d want 0/0", round_winner, match_winner); end
    tests++; if ({freeze, p1_hit, p2_hit} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {freeze, p1_hit, p2_hit}); end
    // Reset on the resolving edge must suppress the pending hit.
    set_pos(200, 100, 250, 100, 1'b0, 1'b0);
    p1_attack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (p2_health !== 4'd15 || p2_hit !== 1'b0) begin fails++; $display("FAIL reset_suppress got %0d/%b want 15/0", p2_health, p2_hit); end
    reset = 1'b0;
    release_wait(1);
  endtask

  task automatic test_basic_hit();
    do_reset();
    set_pos(200, 100, 250, 100, 1'b0, 1'b0);
    attack(1'b1, 1'b0);
    tests++; if (p2_health !== 4'd14) begin fails++; $display("FAIL basic_health got %0d want 14", p2_health); end
    tests++; if (p2_hit !== 1'b1 || p1_hit !== 1'b0) begin fails++; $display("FAIL basic_pulse got p1=%b p2=%b want 0/1", p1_hit, p2_hit); end
    tests++; if (p1_health !== 4'd15) begin fails++; $display("FAIL basic_attacker got %0d want 15", p1_health); end
    @(negedge clk);
    tests++; if (p2_hit !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b want 0", p2_hit); end
    release_wait(2);
    tests++; if (p2_health !== 4'd14) begin fails++; $display("FAIL basic_held got %0d want 14", p2_health); end
  endtask

  task automatic test_blocked_invuln();
    do_reset();
    set_pos(200, 100, 250, 100, 1'b0, 1'b0);
    p2_shield = 1'b1;
    attack(1'b1, 1'b0);
    tests++; if (p2_health !== 4'd15 || p2_hit !== 1'b0) begin fails++; $display("FAIL block_full got %0d/%b want 15/0", p2_health, p2_hit); end
    tests++; if (c_p2_health !== 4'd14 || c_p2_hit !== 1'b1) begin fails++; $display("FAIL block_chip got %0d/%b want 14/1", c_p2_health, c_p2_hit); end
    release_wait(3);
    attack(1'b1, 1'b0);
    tests++; if (c_p2_health !== 4'd14 || c_p2_hit !== 1'b0) begin fails++; $display("FAIL invuln_ignore got %0d/%b want 14/0", c_p2_health, c_p2_hit); end
    release_wait(4);
    attack(1'b1, 1'b0);
    tests++; if (c_p2_health !== 4'd13 || c_p2_hit !== 1'b1) begin fails++; $display("FAIL invuln_expire got %0d/%b want 13/1", c_p2_health, c_p2_hit); end
    tests++; if (p2_health !== 4'd15) begin fails++; $display("FAIL block_full_end got %0d want 15", p2_health); end
    release_wait(1);
    p2_shield = 1'b0;
  endtask

  task automatic test_reject();
    do_reset();
    set_pos(200, 100, 250, 100, 1'b1, 1'b0);
    attack(1'b1, 1'b0);
    tests++; if (p2_health !== 4'd15) begin fails++; $display("FAIL facing_away got %0d want 15", p2_health); end
    release_wait(1);
    set_pos(200, 100, 280, 100, 1'b0, 1'b0);
    attack(1'b1, 1'b0);
    tests++; if (p2_health !== 4'd15) begin fails++; $display("FAIL overlap_edge got %0d want 15", p2_health); end
    release_wait(1);
    set_pos(200, 100, 279, 100, 1'b0, 1'b0);
    attack(1'b1, 1'b0);
    tests++; if (p2_health !== 4'd14) begin fails++; $display("FAIL overlap_inside got %0d want 14", p2_health); end
    release_wait(12);
    set_pos(200, 100, 200, 100, 1'b0, 1'b1);
    attack(1'b1, 1'b1);
    tests++; if (p2_health !== 4'd14 || p1_health !== 4'd15) begin fails++; $display("FAIL equal_x got %0d/%0d want 15/14", p1_health, p2_health); end
    release_wait(1);
    set_pos(200, 100, 250, 101, 1'b0, 1'b0);
    attack(1'b1, 1'b0);
    tests++; if (p2_health !== 4'd14) begin fails++; $display("FAIL y_mismatch got %0d want 14", p2_health); end
    release_wait(1);
  endtask

  task automatic test_trade_draw();
    do_reset();
    set_pos(200, 100, 250, 100, 1'b0, 1'b1);
    repeat (14) begin
      attack(1'b1, 1'b1);
      release_wait(12);
    end
    tests++; if (p1_health !== 4'd1 || p2_health !== 4'd1) begin fails++; $display("FAIL trade_pre got %0d/%0d want 1/1", p1_health, p2_health); end
    attack(1'b1, 1'b1);
    tests++; if (p1_health !== 4'd0 || p2_health !== 4'd0) begin fails++; $display("FAIL trade_health got %0d/%0d want 0/0", p1_health, p2_health); end
    tests++; if (p1_hit !== 1'b1 || p2_hit !== 1'b1) begin fails++; $display("FAIL trade_pulses got %b/%b want 1/1", p1_hit, p2_hit); end
    tests++; if (round_winner !== 2'b11) begin fails++; $display("FAIL trade_winner got %0d want 3", round_winner); end
    tests++; if ({p1_rounds, p2_rounds} !== 4'b0000) begin fails++; $display("FAIL trade_rounds got %0d/%0d want 0/0", p1_rounds, p2_rounds); end
    tests++; if (state !== 2'd1 || freeze !== 1'b1) begin fails++; $display("FAIL trade_state got %0d/%b want 1/1", state, freeze); end
    release_wait(1);
  endtask

  task automatic test_timer();
    do_reset();
    set_pos(200, 100, 250, 100, 1'b0, 1'b0);
    repeat (5) begin
      attack(1'b1, 1'b0);
      release_wait(12);
    end
    tests++; if (p2_health !== 4'd10) begin fails++; $display("FAIL timer_setup got %0d want 10", p2_health); end
    tick_n(1);
    tests++; if (round_timer !== 7'd2 || state !== 2'd0) begin fails++; $display("FAIL timer_tick1 got %0d/%0d want 2/0", round_timer, state); end
    tick_n(2);
    tests++; if (round_timer !== 7'd0 || state !== 2'd1) begin fails++; $display("FAIL timer_expire got %0d/%0d want 0/1", round_timer, state); end
    tests++; if (round_winner !== 2'b01 || p1_rounds !== 2'd1 || p2_rounds !== 2'd0) begin fails++; $display("FAIL timer_winner got %0d r=%0d/%0d want 1 r=1/0", round_winner, p1_rounds, p2_rounds); end
    tests++; if (freeze !== 1'b1) begin fails++; $display("FAIL timer_freeze got %b want 1", freeze); end
    tick_n(2);
    tests++; if (state !== 2'd1 || p2_health !== 4'd10 || round_timer !== 7'd0) begin fails++; $display("FAIL pause_hold got st=%0d h=%0d t=%0d want 1/10/0", state, p2_health, round_timer); end
    tick_n(1);
    tests++; if (p1_health !== 4'd15 || p2_health !== 4'd15) begin fails++; $display("FAIL next_round_health got %0d/%0d want 15/15", p1_health, p2_health); end
    tests++; if (round_timer !== 7'd3 || state !== 2'd0 || freeze !== 1'b0) begin fails++; $display("FAIL next_round_state got t=%0d st=%0d fz=%b want 3/0/0", round_timer, state, freeze); end
    tests++; if (round_winner !== 2'b00) begin fails++; $display("FAIL next_round_winner got %0d want 0", round_winner); end
  endtask

  task automatic test_match_over();
    attack(1'b1, 1'b0);
    release_wait(12);
    tick_n(3);
    tests++; if (state !== 2'd1 || p1_rounds !== 2'd2) begin fails++; $display("FAIL match_round2 got st=%0d r=%0d want 1/2", state, p1_rounds); end
    tick_n(3);
    tests++; if (state !== 2'd2 || match_winner !== 2'b01 || freeze !== 1'b1) begin fails++; $display("FAIL match_over got st=%0d mw=%0d fz=%b want 2/1/1", state, match_winner, freeze); end
    tests++; if (p2_rounds !== 2'd0) begin fails++; $display("FAIL match_p2_rounds got %0d want 0", p2_rounds); end
    attack(1'b1, 1'b0);
    tests++; if (p2_health !== 4'd14 || p2_hit !== 1'b0) begin fails++; $display("FAIL match_attack got %0d/%b want 14/0", p2_health, p2_hit); end
    release_wait(1);
    tick_n(4);
    tests++; if (state !== 2'd2 || round_timer !== 7'd0) begin fails++; $display("FAIL match_hold got st=%0d t=%0d want 2/0", state, round_timer); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++; if (state !== 2'd0 || freeze !== 1'b0 || match_winner !== 2'b00 || round_winner !== 2'b00) begin fails++; $display("FAIL match_reset_state got st=%0d fz=%b mw=%0d rw=%0d want 0/0/0/0", state, freeze, match_winner, round_winner); end
    tests++; if (p1_health !== 4'd15 || p2_health !== 4'd15 || round_timer !== 7'd3 || p1_rounds !== 2'd0) begin fails++; $display("FAIL match_reset_regs got h=%0d/%0d t=%0d r=%0d want 15/15/3/0", p1_health, p2_health, round_timer, p1_rounds); end
  endtask

  initial begin
    reset = 1'b1; sec_tick = 1'b0;
    p1_attack = 1'b0; p2_attack = 1'b0; p1_shield = 1'b0; p2_shield = 1'b0;
    set_pos(0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_basic_hit();
    test_blocked_invuln();
    test_reject();
    test_trade_draw();
    test_timer();
    test_match_over();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
